// File: rtl/iram_pkg.sv
// Shared types and default constants for the instruction-RAM refill responder.
package iram_pkg;

    localparam int IRAM_MEMORY_WORD = 32;
    localparam int IRAM_PC_SIZE     = 32;
    localparam int IRAM_LINE_BEATS  = 4;
    localparam int IRAM_ACCESS_LAT  = 2;
    localparam int IRAM_DEPTH_LOG   = 10;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} iram_state;

    // Width of a counter covering 0..n-1, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iram_mem.sv
// 1-write/1-read synchronous RAM with a registered read port.
// A read and a write to the same word in one cycle return the old contents.
module iram_mem #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [DEPTH_LOG-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [DEPTH_LOG-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [1 << DEPTH_LOG];
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the array and its read register are deliberately left without a
    // reset; clearing a memory needs per-word logic and buys nothing here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/iram_controller.sv
// Instruction-cache refill responder: on a miss, reads one line from the
// internal RAM and returns it as a strobed burst of words, slot 0 first.
module iram_controller
    import iram_pkg::*;
#(
    parameter int PC_SIZE    = IRAM_PC_SIZE,
    parameter int MEM_WORD   = IRAM_MEMORY_WORD,
    parameter int LINE_BEATS = IRAM_LINE_BEATS,
    parameter int ACCESS_LAT = IRAM_ACCESS_LAT,
    parameter int DEPTH_LOG  = IRAM_DEPTH_LOG
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                i_miss,
    input  logic [PC_SIZE-1:0]                  iram_address,
    output logic [MEM_WORD-1:0]                 imem_word,
    output logic                                word_ready,
    output logic [cnt_width(LINE_BEATS)-1:0]    word_idx,
    output logic                                busy,
    input  logic                                prog_we,
    input  logic [DEPTH_LOG-1:0]                prog_addr,
    input  logic [MEM_WORD-1:0]                 prog_data
);

    localparam int IDX_W = cnt_width(LINE_BEATS);
    localparam int LAT_W = cnt_width(ACCESS_LAT);
    localparam logic [DEPTH_LOG-1:0] LINE_MASK = DEPTH_LOG'(LINE_BEATS - 1);
    localparam logic [IDX_W-1:0]     LAST_BEAT = IDX_W'(LINE_BEATS - 1);

    iram_state            state_q, state_d;
    logic [DEPTH_LOG-1:0] base_q, base_d;
    logic [IDX_W-1:0]     beat_q, beat_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [MEM_WORD-1:0]  imem_word_q, imem_word_d;
    logic                 word_ready_q, word_ready_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic                 busy_q, busy_d;

    logic [DEPTH_LOG-1:0] miss_base;
    logic [DEPTH_LOG-1:0] rd_addr;
    logic [MEM_WORD-1:0]  rd_data;
    logic                 unused_addr_bits;

    // Word address modulo the RAM depth, aligned down to the line.
    assign miss_base        = iram_address[DEPTH_LOG+1:2] & ~LINE_MASK;
    assign unused_addr_bits = ^{iram_address[PC_SIZE-1:DEPTH_LOG+2], iram_address[1:0]};

    // The RAM read is issued one cycle ahead of the beat that returns it.
    always_comb begin
        rd_addr = base_q;
        case (state_q)
            IDLE:    rd_addr = miss_base;
            BURST:   rd_addr = base_q + DEPTH_LOG'(beat_q) + DEPTH_LOG'(1);
            default: rd_addr = base_q;
        endcase
    end

    iram_mem #(
        .WIDTH     (MEM_WORD),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_mem (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // NOTE: every _d signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        beat_d       = beat_q;
        lat_d        = lat_q;
        imem_word_d  = imem_word_q;
        word_ready_d = 1'b0;
        word_idx_d   = word_idx_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (i_miss) begin
                    base_d  = miss_base;
                    beat_d  = '0;
                    lat_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (ACCESS_LAT == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!i_miss) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (int'(lat_q) == ACCESS_LAT - 1) begin
                    state_d = BURST;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            BURST: begin
                if (!i_miss) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    word_ready_d = 1'b1;
                    word_idx_d   = beat_q;
                    imem_word_d  = rd_data;
                    beat_d       = beat_q + IDX_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            beat_q       <= '0;
            lat_q        <= '0;
            imem_word_q  <= '0;
            word_ready_q <= 1'b0;
            word_idx_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            beat_q       <= beat_d;
            lat_q        <= lat_d;
            imem_word_q  <= imem_word_d;
            word_ready_q <= word_ready_d;
            word_idx_q   <= word_idx_d;
            busy_q       <= busy_d;
        end
    end

    assign imem_word  = imem_word_q;
    assign word_ready = word_ready_q;
    assign word_idx   = word_idx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_iram_controller.sv
// Directed bench for iram_controller: default build (a) plus an
// ACCESS_LAT=0, DEPTH_LOG=4 build (b) sharing clock, reset and load data.
module tb_iram_controller;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] prog_data;

    logic        miss_a, ready_a, busy_a, prog_we_a;
    logic [31:0] addr_a, word_a;
    logic [1:0]  idx_a;
    logic [9:0]  prog_addr_a;

    logic        miss_b, ready_b, busy_b, prog_we_b;
    logic [31:0] addr_b, word_b;
    logic [1:0]  idx_b;
    logic [3:0]  prog_addr_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iram_controller u_dut_a (
        .clk          (clk),
        .nrst         (nrst),
        .i_miss       (miss_a),
        .iram_address (addr_a),
        .imem_word    (word_a),
        .word_ready   (ready_a),
        .word_idx     (idx_a),
        .busy         (busy_a),
        .prog_we      (prog_we_a),
        .prog_addr    (prog_addr_a),
        .prog_data    (prog_data)
    );

    iram_controller #(
        .ACCESS_LAT (0),
        .DEPTH_LOG  (4)
    ) u_dut_b (
        .clk          (clk),
        .nrst         (nrst),
        .i_miss       (miss_b),
        .iram_address (addr_b),
        .imem_word    (word_b),
        .word_ready   (ready_b),
        .word_idx     (idx_b),
        .busy         (busy_b),
        .prog_we      (prog_we_b),
        .prog_addr    (prog_addr_b),
        .prog_data    (prog_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        miss_a = 1'b0; addr_a = '0; prog_we_a = 1'b0; prog_addr_a = '0;
        miss_b = 1'b0; addr_b = '0; prog_we_b = 1'b0; prog_addr_b = '0;
        prog_data = '0;
        tick();
        tick();
        n_checks++;
        if ({word_a, ready_a, idx_a, busy_a} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_a got word=%h ready=%b idx=%0d busy=%b expected all 0", word_a, ready_a, idx_a, busy_a);
        end
        n_checks++;
        if ({word_b, ready_b, idx_b, busy_b} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_b got word=%h ready=%b idx=%0d busy=%b expected all 0", word_b, ready_b, idx_b, busy_b);
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) begin
            prog_we_a = 1'b1; prog_addr_a = 10'(i);
            prog_we_b = 1'b1; prog_addr_b = 4'(i);
            prog_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        prog_we_a = 1'b0;
        prog_we_b = 1'b0;
    endtask

    task automatic test_basic_refill();
        addr_a = 32'h18;
        miss_a = 1'b1;
        tick();
        n_checks++;
        if (busy_a !== 1'b1 || ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept got busy=%b ready=%b expected busy=1 ready=0", busy_a, ready_a);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if (c < 3) begin
                if (ready_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_wait c=%0d got ready=%b expected 0", c, ready_a);
                end
            end else if ({ready_a, busy_a, idx_a, word_a} !== {2'b11, 2'(c - 3), 32'h1000_0004 + 32'(c - 3)}) begin
                n_fail++;
                $display("FAIL basic_beat c=%0d got ready=%b busy=%b idx=%0d word=%h expected idx=%0d word=%h",
                         c, ready_a, busy_a, idx_a, word_a, c - 3, 32'h1000_0004 + 32'(c - 3));
            end
        end
        miss_a = 1'b0;
        tick();
        n_checks++;
        if ({ready_a, busy_a, word_a} !== {2'b00, 32'h1000_0007}) begin
            n_fail++;
            $display("FAIL basic_done got ready=%b busy=%b word=%h expected 0 0 10000007", ready_a, busy_a, word_a);
        end
        tick();
    endtask

    task automatic test_abort();
        addr_a = 32'h18;
        miss_a = 1'b1;
        tick();
        tick();
        tick();
        for (int b = 0; b < 2; b++) begin
            tick();
            n_checks++;
            if ({ready_a, idx_a, word_a} !== {1'b1, 2'(b), 32'h1000_0004 + 32'(b)}) begin
                n_fail++;
                $display("FAIL abort_pre b=%0d got ready=%b idx=%0d word=%h expected word=%h",
                         b, ready_a, idx_a, word_a, 32'h1000_0004 + 32'(b));
            end
        end
        miss_a = 1'b0;
        tick();
        n_checks++;
        if ({ready_a, busy_a, word_a} !== {2'b00, 32'h1000_0005}) begin
            n_fail++;
            $display("FAIL abort_stop got ready=%b busy=%b word=%h expected 0 0 10000005", ready_a, busy_a, word_a);
        end
        addr_a = 32'h20;
        miss_a = 1'b1;
        tick();
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if (c < 3) begin
                if (ready_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_wait c=%0d got ready=%b expected 0", c, ready_a);
                end
            end else if ({ready_a, idx_a, word_a} !== {1'b1, 2'(c - 3), 32'h1000_0008 + 32'(c - 3)}) begin
                n_fail++;
                $display("FAIL abort_restart c=%0d got ready=%b idx=%0d word=%h expected idx=%0d word=%h",
                         c, ready_a, idx_a, word_a, c - 3, 32'h1000_0008 + 32'(c - 3));
            end
        end
        miss_a = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_lat0();
        addr_b = 32'h0;
        miss_b = 1'b1;
        tick();
        n_checks++;
        if (busy_b !== 1'b1 || ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL lat0_accept got busy=%b ready=%b expected busy=1 ready=0", busy_b, ready_b);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            n_checks++;
            if ({ready_b, idx_b, word_b} !== {1'b1, 2'(b), 32'h1000_0000 + 32'(b)}) begin
                n_fail++;
                $display("FAIL lat0_beat b=%0d got ready=%b idx=%0d word=%h expected word=%h",
                         b, ready_b, idx_b, word_b, 32'h1000_0000 + 32'(b));
            end
        end
        miss_b = 1'b0;
        tick();
        n_checks++;
        if (ready_b !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL lat0_done got ready=%b busy=%b expected 0 0", ready_b, busy_b);
        end
        tick();
    endtask

    task automatic test_wrap();
        // 0x7C in a 16-word RAM and 0x1034 in a 1024-word RAM both land on line 12.
        addr_b = 32'h7C;
        miss_b = 1'b1;
        tick();
        for (int b = 0; b < 4; b++) begin
            tick();
            n_checks++;
            if ({ready_b, idx_b, word_b} !== {1'b1, 2'(b), 32'h1000_000C + 32'(b)}) begin
                n_fail++;
                $display("FAIL wrap_b b=%0d got ready=%b idx=%0d word=%h expected word=%h",
                         b, ready_b, idx_b, word_b, 32'h1000_000C + 32'(b));
            end
        end
        miss_b = 1'b0;
        addr_a = 32'h1034;
        miss_a = 1'b1;
        tick();
        tick();
        tick();
        for (int b = 0; b < 4; b++) begin
            tick();
            n_checks++;
            if ({ready_a, idx_a, word_a} !== {1'b1, 2'(b), 32'h1000_000C + 32'(b)}) begin
                n_fail++;
                $display("FAIL wrap_a b=%0d got ready=%b idx=%0d word=%h expected word=%h",
                         b, ready_a, idx_a, word_a, 32'h1000_000C + 32'(b));
            end
        end
        miss_a = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_collision();
        logic [31:0] exp1 [4];
        logic [31:0] exp2 [4];
        exp1 = '{32'h1000_0000, 32'h1000_0001, 32'hDEAD_BEEF, 32'h1000_0003};
        exp2 = '{32'h1000_0000, 32'h1000_0001, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        addr_a = 32'h0;
        miss_a = 1'b1;
        tick();
        // Write word 2 during WAIT; beat 2 is read later and must see it.
        prog_we_a = 1'b1; prog_addr_a = 10'd2; prog_data = 32'hDEAD_BEEF;
        tick();
        prog_we_a = 1'b0;
        tick();
        for (int b = 0; b < 4; b++) begin
            // Word 3 is read at the same edge as this write: old data expected.
            if (b == 2) begin
                prog_we_a = 1'b1; prog_addr_a = 10'd3; prog_data = 32'hCAFE_F00D;
            end
            tick();
            prog_we_a = 1'b0;
            n_checks++;
            if ({ready_a, idx_a, word_a} !== {1'b1, 2'(b), exp1[b]}) begin
                n_fail++;
                $display("FAIL collide_beat b=%0d got ready=%b idx=%0d word=%h expected word=%h",
                         b, ready_a, idx_a, word_a, exp1[b]);
            end
        end
        miss_a = 1'b0;
        tick();
        tick();
        miss_a = 1'b1;
        tick();
        tick();
        tick();
        for (int b = 0; b < 4; b++) begin
            tick();
            n_checks++;
            if ({ready_a, idx_a, word_a} !== {1'b1, 2'(b), exp2[b]}) begin
                n_fail++;
                $display("FAIL collide_reread b=%0d got ready=%b idx=%0d word=%h expected word=%h",
                         b, ready_a, idx_a, word_a, exp2[b]);
            end
        end
        miss_a = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        addr_a = 32'h10;
        miss_a = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        n_checks++;
        if ({ready_a, idx_a, word_a} !== {1'b1, 2'd1, 32'h1000_0005}) begin
            n_fail++;
            $display("FAIL rstmid_beat1 got ready=%b idx=%0d word=%h expected 1 1 10000005", ready_a, idx_a, word_a);
        end
        nrst = 1'b0;
        tick();
        n_checks++;
        if ({word_a, ready_a, idx_a, busy_a} !== 36'h0) begin
            n_fail++;
            $display("FAIL rstmid_clear got word=%h ready=%b idx=%0d busy=%b expected all 0", word_a, ready_a, idx_a, busy_a);
        end
        nrst = 1'b1;
        addr_a = 32'h30;
        tick();
        n_checks++;
        if (busy_a !== 1'b1 || ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_accept got busy=%b ready=%b expected busy=1 ready=0", busy_a, ready_a);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if (c < 3) begin
                if (ready_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_wait c=%0d got ready=%b expected 0", c, ready_a);
                end
            end else if ({ready_a, idx_a, word_a} !== {1'b1, 2'(c - 3), 32'h1000_000C + 32'(c - 3)}) begin
                n_fail++;
                $display("FAIL rstmid_refill c=%0d got ready=%b idx=%0d word=%h expected idx=%0d word=%h",
                         c, ready_a, idx_a, word_a, c - 3, 32'h1000_000C + 32'(c - 3));
            end
        end
        miss_a = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        preload();
        test_basic_refill();
        test_abort();
        test_lat0();
        test_wrap();
        test_collision();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iram_controller.md
Name: iram_controller

Overview:
- Responder for the core's instruction-cache refill interface. It receives a miss address, reads one full cache line from its internal instruction memory and returns the line as a burst of words, each marked valid with a strobe.
- Sits outside the core. Its outputs drive the core's word input and word-valid strobe; its inputs are driven by the core's refill address and miss request.
- Contains a program-load port used by the bench and boot logic to fill instruction memory.

Parameters:
- PC_SIZE, 32, width of the byte address sent by the core.
- MEM_WORD, 32, width of one returned word.
- LINE_BEATS, 4, words per cache line; power of 2, at least 1.
- ACCESS_LAT, 2, wait cycles between accepting a miss and the first beat; 0 is legal.
- DEPTH_LOG, 10, log2 of the instruction memory depth in words.

Ports:
- clk  in  1  clock
- nrst  in  1  reset: synchronous, active-low
- i_miss  in  1  refill request; level signal, held by the core until the line is delivered
- iram_address  in  PC_SIZE  byte address of the missing instruction
- imem_word  out  MEM_WORD  returned word
- word_ready  out  1  imem_word is valid this cycle
- word_idx  out  log2(LINE_BEATS) (minimum 1)  slot of the current beat within the line
- busy  out  1  a refill is in progress
- prog_we  in  1  program-load write enable
- prog_addr  in  DEPTH_LOG  program-load word address
- prog_data  in  MEM_WORD  program-load data

Behaviour:
- Reset values: imem_word=0, word_ready=0, word_idx=0, busy=0, FSM=IDLE. Memory contents are not reset.
- Word address is iram_address[PC_SIZE-1:2]. Line base is the word address with its low log2(LINE_BEATS) bits cleared, taken modulo 2^DEPTH_LOG.
- All outputs are registered.
- FSM states: IDLE, WAIT, BURST, DONE.
  - IDLE: when i_miss=1, latch the line base, clear the latency and beat counters, set busy=1. Go to WAIT, or straight to BURST if ACCESS_LAT=0.
  - WAIT: count ACCESS_LAT cycles, then go to BURST.
  - BURST: each cycle drive word_ready=1, word_idx=beat, imem_word=mem[(base+beat) mod depth], then increment beat. After beat LINE_BEATS-1, go to DONE.
  - DONE: one cycle with word_ready=0 and busy=0. i_miss is ignored in this cycle so the core can deassert it. Go to IDLE.
- Latency: miss sampled in IDLE at edge t. First word_ready is visible after edge t+ACCESS_LAT+1, and beats are contiguous. Minimum gap between two refills is 2 cycles (DONE, then IDLE sampling).
- Beat order is always ascending from slot 0. There is no critical-word-first.
- Abort: if i_miss=0 is sampled in WAIT or BURST (e.g. a flush), go to IDLE on the next edge with word_ready=0 and busy=0. A partial line is not completed.
- Outside BURST, word_ready=0 and imem_word holds its last value.
- Program load: a write takes effect at the edge where prog_we=1 is sampled, in any state.
  - Read/write to the same word in the same cycle returns the old data.
  - A write landing in the line being bursted is visible for beats read in later cycles.
- Address wrap: a line base near the top of memory wraps to the low addresses. There is no error output.
- Reset mid-burst: all outputs return to reset values on the next edge; the refill is discarded.

Decomposition:
- Shared package gets the state enum iram_state {IDLE, WAIT, BURST, DONE} and the default constants IRAM_LINE_BEATS and IRAM_ACCESS_LAT, next to the existing memory_word and pc_size defines.
- One natural sub-module: iram_mem, a 1-write/1-read synchronous RAM with registered read-data out and read-old-on-collision behaviour.
- The FSM and counters live in iram_controller.

Test Plan:
- Basic refill: preload mem[i]=0x1000_0000+i for i=0..15; hold i_miss=1 with iram_address=0x18 -> word_ready high exactly at cycles t+3..t+6 carrying 0x10000004..0x10000007 with word_idx 0..3, then one DONE cycle with busy=0.
- ACCESS_LAT=0 build: iram_address=0x0 -> first word_ready one cycle after the miss is sampled, 4 contiguous beats, 0x10000000..0x10000003.
- Abort: drop i_miss after the 2nd beat -> next cycle word_ready=0 and busy=0; re-assert with 0x20 -> fresh burst of 0x10000008..0x1000000B from slot 0.
- Wrap/unaligned: DEPTH_LOG=4, iram_address=0x7C -> line base word 28 mod 16 = 12, returns mem[12..15].
- Collision: during the WAIT of a refill to line 0, write prog_addr=2 with 0xDEADBEEF -> beat 2 returns 0xDEADBEEF. A same-cycle write/read to one word returns the old value.
- Reset mid-burst: assert nrst=0 at beat 1 -> next edge word_ready=0, imem_word=0, busy=0, FSM=IDLE. Memory is retained, and a new miss returns the correct data.
